// File: rtl/axi_riscv_amo_initiator.sv
// rtl/axi_riscv_amo_initiator.sv - RISC-V LR/SC/AMO requests issued as single-beat AXI5 (ATOP) transactions
// Optional feature: define AXI_RISCV_AMO_INIT_SC_FAIL_FAST_EN for a local LR reservation that fails SCs early.
module axi_riscv_amo_initiator #(
  parameter int AXI_ADDR_WIDTH   = 0,
  parameter int AXI_DATA_WIDTH   = 0,
  parameter int AXI_ID_WIDTH     = 0,
  parameter int AXI_USER_WIDTH   = 0,
  parameter int RISCV_WORD_WIDTH = 0,
  parameter int AXI_ID           = 0,
  localparam int AW = (AXI_ADDR_WIDTH > 0) ? AXI_ADDR_WIDTH : 1,
  localparam int RW = (RISCV_WORD_WIDTH == 64) ? 64 : 32,
  localparam int DW = (AXI_DATA_WIDTH > RW) ? AXI_DATA_WIDTH : RW,
  localparam int IW = (AXI_ID_WIDTH > 0) ? AXI_ID_WIDTH : 1,
  localparam int UW = (AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1,
  localparam int SW = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [3:0]    req_op_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [1:0]    req_size_i,
  input  logic [RW-1:0] req_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [RW-1:0] rsp_rdata_o,
  output logic          rsp_err_o,
  output logic [IW-1:0] mst_aw_id,
  output logic [AW-1:0] mst_aw_addr,
  output logic [7:0]    mst_aw_len,
  output logic [2:0]    mst_aw_size,
  output logic [1:0]    mst_aw_burst,
  output logic          mst_aw_lock,
  output logic [3:0]    mst_aw_cache,
  output logic [2:0]    mst_aw_prot,
  output logic [3:0]    mst_aw_qos,
  output logic [3:0]    mst_aw_region,
  output logic [5:0]    mst_aw_atop,
  output logic [UW-1:0] mst_aw_user,
  output logic          mst_aw_valid,
  input  logic          mst_aw_ready,
  output logic [DW-1:0] mst_w_data,
  output logic [SW-1:0] mst_w_strb,
  output logic          mst_w_last,
  output logic [UW-1:0] mst_w_user,
  output logic          mst_w_valid,
  input  logic          mst_w_ready,
  input  logic [IW-1:0] mst_b_id,
  input  logic [1:0]    mst_b_resp,
  input  logic [UW-1:0] mst_b_user,
  input  logic          mst_b_valid,
  output logic          mst_b_ready,
  output logic [IW-1:0] mst_ar_id,
  output logic [AW-1:0] mst_ar_addr,
  output logic [7:0]    mst_ar_len,
  output logic [2:0]    mst_ar_size,
  output logic [1:0]    mst_ar_burst,
  output logic          mst_ar_lock,
  output logic [3:0]    mst_ar_cache,
  output logic [2:0]    mst_ar_prot,
  output logic [3:0]    mst_ar_qos,
  output logic [3:0]    mst_ar_region,
  output logic [UW-1:0] mst_ar_user,
  output logic          mst_ar_valid,
  input  logic          mst_ar_ready,
  input  logic [IW-1:0] mst_r_id,
  input  logic [DW-1:0] mst_r_data,
  input  logic [1:0]    mst_r_resp,
  input  logic          mst_r_last,
  input  logic [UW-1:0] mst_r_user,
  input  logic          mst_r_valid,
  output logic          mst_r_ready
);

  localparam logic [3:0] OP_LR   = 4'd0;
  localparam logic [3:0] OP_SC   = 4'd1;
  localparam logic [3:0] OP_SWAP = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_MIN  = 4'd7;
  localparam logic [3:0] OP_MAX  = 4'd8;
  localparam logic [3:0] OP_MINU = 4'd9;
  localparam logic [3:0] OP_MAXU = 4'd10;
  localparam int LB = (SW > 1) ? $clog2(SW) : 1;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [IW-1:0] ID_C = IW'(AXI_ID);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WAIT_WR, S_READ, S_WAIT_R, S_RSP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    size_q;
  logic [RW-1:0] wdata_q;
  logic [RW-1:0] rdata_q;
  logic          err_q;
  logic          aw_done_q, w_done_q, b_done_q, r_done_q;

  logic          accept, req_bad, sc_fast;
  logic [2:0]    req_low3;
  logic          is_amo;
  logic          aw_hs, w_hs, b_hs, r_hs, ar_hs;
  logic          b_bad, r_bad;
  logic [LB-1:0] lane;
  logic [DW-1:0] r_shift;
  logic [RW-1:0] rd_ext;
  logic [RW-1:0] op_word;
  logic [SW-1:0] strb_base;
  logic [5:0]    atop;
  logic          unused_bits;

  assign accept = req_valid_i && req_ready_o;
  assign is_amo = (op_q >= OP_SWAP);
  assign aw_hs  = mst_aw_valid && mst_aw_ready;
  assign w_hs   = mst_w_valid && mst_w_ready;
  assign b_hs   = mst_b_valid && mst_b_ready;
  assign ar_hs  = mst_ar_valid && mst_ar_ready;
  assign r_hs   = mst_r_valid && mst_r_ready;
  assign b_bad  = mst_b_resp[1] || (mst_b_id != ID_C);
  assign r_bad  = mst_r_resp[1] || (mst_r_id != ID_C);
  assign lane   = LB'(addr_q);

  always_comb begin
    req_low3 = 3'(req_addr_i);
    req_bad  = (req_op_i > OP_MAXU);
    if (req_size_i == 2'd2) begin
      if (req_low3[1:0] != 2'b00) req_bad = 1'b1;
    end else if (req_size_i == 2'd3) begin
      if (req_low3 != 3'b000 || RW == 32) req_bad = 1'b1;
    end else begin
      req_bad = 1'b1;
    end
  end

`ifdef AXI_RISCV_AMO_INIT_SC_FAIL_FAST_EN
  logic          res_valid_q;
  logic [AW-1:0] res_addr_q;

  // Only a clean LR arms the reservation; any store-like accept disarms it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
    end else if (accept && req_op_i >= OP_SC && req_op_i <= OP_MAXU) begin
      res_valid_q <= 1'b0;
    end else if (state_q == S_WAIT_R && r_hs && !(err_q || r_bad)) begin
      res_valid_q <= 1'b1;
      res_addr_q  <= addr_q;
    end
  end

  assign sc_fast = (req_op_i == OP_SC) && !(res_valid_q && res_addr_q == req_addr_i);
`else
  assign sc_fast = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_bad || sc_fast)   state_d = S_RSP;
          else if (req_op_i == OP_LR) state_d = S_READ;
          else                      state_d = S_WRITE;
        end
      end
      S_WRITE:   if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WAIT_WR;
      S_WAIT_WR: if ((b_done_q || b_hs) && (!is_amo || r_done_q || r_hs)) state_d = S_RSP;
      S_READ:    if (ar_hs) state_d = S_WAIT_R;
      S_WAIT_R:  if (r_hs) state_d = S_RSP;
      S_RSP:     if (rsp_ready_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Every handshake-facing output is forced low while reset is held.
  always_comb begin
    req_ready_o  = !rst_i && (state_q == S_IDLE);
    mst_aw_valid = !rst_i && (state_q == S_WRITE) && !aw_done_q;
    mst_w_valid  = !rst_i && (state_q == S_WRITE) && !w_done_q;
    mst_ar_valid = !rst_i && (state_q == S_READ);
    mst_b_ready  = !rst_i && (state_q == S_WAIT_WR);
    mst_r_ready  = !rst_i && ((state_q == S_WAIT_R) || (state_q == S_WAIT_WR && is_amo));
    rsp_valid_o  = !rst_i && (state_q == S_RSP);
    rsp_rdata_o  = rsp_valid_o ? rdata_q : '0;
    rsp_err_o    = rsp_valid_o && err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q      <= OP_LR;
      addr_q    <= '0;
      size_q    <= 2'd0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      r_done_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= req_op_i;
        addr_q    <= req_addr_i;
        size_q    <= req_size_i;
        wdata_q   <= req_wdata_i;
        rdata_q   <= (!req_bad && sc_fast) ? RW'(1) : '0;
        err_q     <= req_bad;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        b_done_q  <= 1'b0;
        r_done_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (b_hs)  b_done_q  <= 1'b1;
      if (r_hs)  r_done_q  <= 1'b1;
      if (b_hs || r_hs) err_q <= err_q || (b_hs && b_bad) || (r_hs && r_bad);
      if (r_hs) rdata_q <= rd_ext;
      else if (b_hs && op_q == OP_SC) rdata_q <= (mst_b_resp == RESP_EXOKAY) ? '0 : RW'(1);
    end
  end

  always_comb begin
    r_shift = mst_r_data >> {lane, 3'b000};
    if (size_q == 2'd3) rd_ext = r_shift[RW-1:0];
    else                rd_ext = RW'($signed(r_shift[31:0]));
  end

  // AMOAND maps to ATOP CLR, which clears the bits set in W, hence the inversion.
  always_comb begin
    op_word = (op_q == OP_AND) ? ~wdata_q : wdata_q;
    if (size_q != 2'd3) op_word = RW'(op_word[31:0]);
    strb_base = (size_q == 2'd3) ? SW'(8'hFF) : SW'(4'hF);
  end

  always_comb begin
    case (op_q)
      OP_SWAP: atop = 6'h30;
      OP_ADD:  atop = 6'h20;
      OP_XOR:  atop = 6'h22;
      OP_AND:  atop = 6'h21;
      OP_OR:   atop = 6'h23;
      OP_MIN:  atop = 6'h25;
      OP_MAX:  atop = 6'h24;
      OP_MINU: atop = 6'h27;
      OP_MAXU: atop = 6'h26;
      default: atop = 6'h00;
    endcase
  end

  assign mst_aw_id     = ID_C;
  assign mst_aw_addr   = addr_q;
  assign mst_aw_len    = 8'd0;
  assign mst_aw_size   = {1'b0, size_q};
  assign mst_aw_burst  = 2'b01;
  assign mst_aw_lock   = (op_q == OP_SC);
  assign mst_aw_cache  = 4'd0;
  assign mst_aw_prot   = 3'd0;
  assign mst_aw_qos    = 4'd0;
  assign mst_aw_region = 4'd0;
  assign mst_aw_atop   = atop;
  assign mst_aw_user   = '0;
  assign mst_w_data    = DW'(op_word) << {lane, 3'b000};
  assign mst_w_strb    = strb_base << lane;
  assign mst_w_last    = 1'b1;
  assign mst_w_user    = '0;
  assign mst_ar_id     = ID_C;
  assign mst_ar_addr   = addr_q;
  assign mst_ar_len    = 8'd0;
  assign mst_ar_size   = {1'b0, size_q};
  assign mst_ar_burst  = 2'b01;
  assign mst_ar_lock   = 1'b1;
  assign mst_ar_cache  = 4'd0;
  assign mst_ar_prot   = 3'd0;
  assign mst_ar_qos    = 4'd0;
  assign mst_ar_region = 4'd0;
  assign mst_ar_user   = '0;

  assign unused_bits = ^{mst_b_user, mst_r_user, mst_r_last, r_shift};

endmodule

// File: tb/tb_axi_riscv_amo_initiator.sv
// tb/tb_axi_riscv_amo_initiator.sv - directed self-checking bench for axi_riscv_amo_initiator
module tb_axi_riscv_amo_initiator;
  localparam int AW = 32, DW = 64, IW = 4, UW = 2, RW = 64, ID = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [3:0] req_op;
  logic [AW-1:0] req_addr;
  logic [1:0] req_size;
  logic [RW-1:0] req_wdata, rsp_rdata;
  logic [IW-1:0] aw_id, b_id, ar_id, r_id;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [7:0] aw_len, ar_len;
  logic [2:0] aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0] aw_burst, ar_burst, b_resp, r_resp;
  logic aw_lock, ar_lock, aw_valid, aw_ready, w_last, w_valid, w_ready;
  logic b_valid, b_ready, ar_valid, ar_ready, r_last, r_valid, r_ready;
  logic [3:0] aw_cache, aw_qos, aw_region, ar_cache, ar_qos, ar_region;
  logic [5:0] aw_atop;
  logic [UW-1:0] aw_user, w_user, b_user, ar_user, r_user;
  logic [DW-1:0] w_data, r_data;
  logic [DW/8-1:0] w_strb;

  axi_riscv_amo_initiator #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
    .AXI_USER_WIDTH(UW), .RISCV_WORD_WIDTH(RW), .AXI_ID(ID)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mst_aw_id(aw_id), .mst_aw_addr(aw_addr), .mst_aw_len(aw_len), .mst_aw_size(aw_size),
    .mst_aw_burst(aw_burst), .mst_aw_lock(aw_lock), .mst_aw_cache(aw_cache), .mst_aw_prot(aw_prot),
    .mst_aw_qos(aw_qos), .mst_aw_region(aw_region), .mst_aw_atop(aw_atop), .mst_aw_user(aw_user),
    .mst_aw_valid(aw_valid), .mst_aw_ready(aw_ready),
    .mst_w_data(w_data), .mst_w_strb(w_strb), .mst_w_last(w_last), .mst_w_user(w_user),
    .mst_w_valid(w_valid), .mst_w_ready(w_ready),
    .mst_b_id(b_id), .mst_b_resp(b_resp), .mst_b_user(b_user), .mst_b_valid(b_valid), .mst_b_ready(b_ready),
    .mst_ar_id(ar_id), .mst_ar_addr(ar_addr), .mst_ar_len(ar_len), .mst_ar_size(ar_size),
    .mst_ar_burst(ar_burst), .mst_ar_lock(ar_lock), .mst_ar_cache(ar_cache), .mst_ar_prot(ar_prot),
    .mst_ar_qos(ar_qos), .mst_ar_region(ar_region), .mst_ar_user(ar_user),
    .mst_ar_valid(ar_valid), .mst_ar_ready(ar_ready),
    .mst_r_id(r_id), .mst_r_data(r_data), .mst_r_resp(r_resp), .mst_r_last(r_last),
    .mst_r_user(r_user), .mst_r_valid(r_valid), .mst_r_ready(r_ready)
  );

  int n_assert = 0, n_fail = 0;
  int aw_cycles = 0, ar_cycles = 0, rsp_count = 0;

  always @(posedge clk) begin
    if (aw_valid) aw_cycles++;
    if (ar_valid) ar_cycles++;
    if (rsp_valid && rsp_ready) rsp_count++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [1:0] size, input logic [63:0] wd);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_size = size; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic write_both();
    aw_ready = 1'b1; w_ready = 1'b1;
    step();
    aw_ready = 1'b0; w_ready = 1'b0;
  endtask

  task automatic give_b(input logic [1:0] resp, input logic [3:0] id);
    b_valid = 1'b1; b_resp = resp; b_id = id;
    step();
    b_valid = 1'b0;
  endtask

  task automatic give_r(input logic [1:0] resp, input logic [3:0] id, input logic [63:0] data);
    r_valid = 1'b1; r_resp = resp; r_id = id; r_data = data;
    step();
    r_valid = 1'b0;
  endtask

  task automatic give_br(input logic [1:0] bresp, input logic [1:0] rresp, input logic [3:0] rid, input logic [63:0] data);
    b_valid = 1'b1; b_resp = bresp; b_id = 4'(ID);
    r_valid = 1'b1; r_resp = rresp; r_id = rid; r_data = data;
    step();
    b_valid = 1'b0; r_valid = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  logic [5:0] atop_exp [0:8];
  int aw0, ar0, rc0;
  logic [63:0] held;

  initial begin
    atop_exp = '{6'h30, 6'h20, 6'h22, 6'h21, 6'h23, 6'h25, 6'h24, 6'h27, 6'h26};
    rst = 1'b1; req_valid = 0; req_op = 0; req_addr = 0; req_size = 0; req_wdata = 0; rsp_ready = 0;
    aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; b_resp = 0; b_id = 0; b_user = 0;
    r_valid = 0; r_resp = 0; r_id = 0; r_data = 0; r_last = 1; r_user = 0;
    step(); step();
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_aw_valid", 64'(aw_valid), 0);
    chk("rst_ar_valid", 64'(ar_valid), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", 64'(rsp_err), 0);
    rst = 1'b0;
    step();
    chk("idle_req_ready", 64'(req_ready), 1);

    // AMOADD.W in the upper lane, sign-extended result, 3-cycle latency
    send(4'd3, 32'h1004, 2'd2, 64'd5);
    chk("add_aw_valid", 64'(aw_valid), 1);
    chk("add_w_valid", 64'(w_valid), 1);
    chk("add_atop", 64'(aw_atop), 64'h20);
    chk("add_strb", 64'(w_strb), 64'hF0);
    chk("add_wdata", w_data, 64'h00000005_00000000);
    chk("add_aw_addr", 64'(aw_addr), 64'h1004);
    chk("add_aw_size", 64'(aw_size), 2);
    chk("add_aw_id", 64'(aw_id), 3);
    chk("add_aw_lock", 64'(aw_lock), 0);
    chk("add_w_last", 64'(w_last), 1);
    chk("add_req_ready", 64'(req_ready), 0);
    write_both();
    chk("add_aw_drop", 64'(aw_valid), 0);
    chk("add_b_ready", 64'(b_ready), 1);
    chk("add_r_ready", 64'(r_ready), 1);
    chk("add_rsp_early", 64'(rsp_valid), 0);
    give_br(2'b00, 2'b00, 4'(ID), 64'hFFFFFFFF_00000000);
    chk("add_rsp_valid", 64'(rsp_valid), 1);
    chk("add_rdata", rsp_rdata, 64'hFFFFFFFF_FFFFFFFF);
    chk("add_err", 64'(rsp_err), 0);
    take_rsp();
    chk("add_rsp_done", 64'(rsp_valid), 0);
    chk("add_back_idle", 64'(req_ready), 1);
    chk("add_rsp_count", 64'(rsp_count), 1);

    // LR.D then SC.D, EXOKAY and OKAY
    send(4'd0, 32'h2000, 2'd3, 64'd0);
    chk("lr_ar_valid", 64'(ar_valid), 1);
    chk("lr_ar_lock", 64'(ar_lock), 1);
    chk("lr_ar_size", 64'(ar_size), 3);
    chk("lr_ar_addr", 64'(ar_addr), 64'h2000);
    chk("lr_ar_len", 64'(ar_len), 0);
    chk("lr_ar_burst", 64'(ar_burst), 1);
    chk("lr_no_aw", 64'(aw_valid), 0);
    step();
    chk("lr_ar_hold", 64'(ar_valid), 1);
    ar_ready = 1'b1; step(); ar_ready = 1'b0;
    chk("lr_ar_drop", 64'(ar_valid), 0);
    chk("lr_r_ready", 64'(r_ready), 1);
    give_r(2'b01, 4'(ID), 64'h11223344_55667788);
    chk("lr_rdata", rsp_rdata, 64'h11223344_55667788);
    chk("lr_err", 64'(rsp_err), 0);
    take_rsp();
    send(4'd1, 32'h2000, 2'd3, 64'hAABB);
    chk("sc_aw_valid", 64'(aw_valid), 1);
    chk("sc_aw_lock", 64'(aw_lock), 1);
    chk("sc_atop", 64'(aw_atop), 0);
    chk("sc_strb", 64'(w_strb), 64'hFF);
    chk("sc_wdata", w_data, 64'hAABB);
    w_ready = 1'b1; step(); w_ready = 1'b0;
    chk("sc_w_first", 64'(w_valid), 0);
    chk("sc_aw_hold", 64'(aw_valid), 1);
    aw_ready = 1'b1; step(); aw_ready = 1'b0;
    chk("sc_b_ready", 64'(b_ready), 1);
    chk("sc_no_r_ready", 64'(r_ready), 0);
    give_b(2'b01, 4'(ID));
    chk("sc_ok_rdata", rsp_rdata, 0);
    chk("sc_ok_err", 64'(rsp_err), 0);
    take_rsp();
    send(4'd0, 32'h2000, 2'd3, 64'd0);
    ar_ready = 1'b1; step(); ar_ready = 1'b0;
    give_r(2'b01, 4'(ID), 64'd5);
    take_rsp();
    send(4'd1, 32'h2000, 2'd3, 64'd1);
    write_both();
    give_b(2'b00, 4'(ID));
    chk("sc_fail_rdata", rsp_rdata, 1);
    chk("sc_fail_err", 64'(rsp_err), 0);
    take_rsp();

    // AMOAND.D with B/R completing in all three orders
    for (int m = 0; m < 3; m++) begin
      rc0 = rsp_count;
      send(4'd5, 32'h3008, 2'd3, 64'h00FF);
      chk("and_atop", 64'(aw_atop), 64'h21);
      chk("and_wdata", w_data, 64'hFFFFFFFF_FFFFFF00);
      chk("and_strb", 64'(w_strb), 64'hFF);
      write_both();
      if (m == 0) begin
        give_br(2'b00, 2'b00, 4'(ID), 64'h0F0F0F0F_0F0F0F0F + 64'(m));
      end else if (m == 1) begin
        give_b(2'b00, 4'(ID));
        chk("and_b_only", 64'(rsp_valid), 0);
        give_r(2'b00, 4'(ID), 64'h0F0F0F0F_0F0F0F0F + 64'(m));
      end else begin
        give_r(2'b00, 4'(ID), 64'h0F0F0F0F_0F0F0F0F + 64'(m));
        chk("and_r_only", 64'(rsp_valid), 0);
        give_b(2'b00, 4'(ID));
      end
      chk("and_rsp_valid", 64'(rsp_valid), 1);
      chk("and_rdata", rsp_rdata, 64'h0F0F0F0F_0F0F0F0F + 64'(m));
      take_rsp();
      chk("and_one_rsp", 64'(rsp_count - rc0), 1);
      chk("and_rsp_done", 64'(rsp_valid), 0);
    end

    // Illegal requests: no bus traffic, immediate error response
    aw0 = aw_cycles; ar0 = ar_cycles;
    send(4'd2, 32'h1002, 2'd2, 64'd1);
    chk("mis_rsp_valid", 64'(rsp_valid), 1);
    chk("mis_err", 64'(rsp_err), 1);
    chk("mis_rdata", rsp_rdata, 0);
    take_rsp();
    send(4'd12, 32'h1000, 2'd2, 64'd1);
    chk("op12_rsp_valid", 64'(rsp_valid), 1);
    chk("op12_err", 64'(rsp_err), 1);
    take_rsp();
    send(4'd3, 32'h1004, 2'd3, 64'd1);
    chk("misd_err", 64'(rsp_err), 1);
    take_rsp();
    send(4'd3, 32'h1000, 2'd1, 64'd1);
    chk("size1_err", 64'(rsp_err), 1);
    take_rsp();
    chk("bad_no_aw", 64'(aw_cycles - aw0), 0);
    chk("bad_no_ar", 64'(ar_cycles - ar0), 0);

    // Response back-pressure: AMOMAX.W lane 0, negative word
    send(4'd8, 32'h1000, 2'd2, 64'd7);
    chk("max_strb", 64'(w_strb), 64'h0F);
    chk("max_wdata", w_data, 64'd7);
    write_both();
    give_br(2'b00, 2'b00, 4'(ID), 64'h12345678_80000000);
    held = 64'hFFFFFFFF_80000000;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 1);
      chk("bp_rdata", rsp_rdata, held);
      chk("bp_req_ready", 64'(req_ready), 0);
      step();
    end
    take_rsp();

    // ATOP encoding across every AMO, plus response error detection
    for (int k = 0; k < 9; k++) begin
      send(4'(k + 2), 32'h1000, 2'd2, 64'd1);
      chk("atop_table", 64'(aw_atop), 64'(atop_exp[k]));
      write_both();
      if (k == 7) give_br(2'b00, 2'b00, 4'd5, 64'd0);
      else if (k == 5) give_br(2'b10, 2'b00, 4'(ID), 64'd0);
      else give_br(2'b00, 2'b00, 4'(ID), 64'd0);
      chk("atop_err", 64'(rsp_err), (k == 7 || k == 5) ? 64'd1 : 64'd0);
      take_rsp();
    end

    // Reset during WAIT_WR aborts the transaction
    send(4'd4, 32'h1000, 2'd2, 64'd1);
    write_both();
    chk("abort_in_wait_wr", 64'(b_ready), 1);
    rst = 1'b1;
    step();
    chk("abort_req_ready", 64'(req_ready), 0);
    chk("abort_b_ready", 64'(b_ready), 0);
    chk("abort_r_ready", 64'(r_ready), 0);
    chk("abort_aw_valid", 64'(aw_valid), 0);
    chk("abort_w_valid", 64'(w_valid), 0);
    chk("abort_ar_valid", 64'(ar_valid), 0);
    chk("abort_rsp_valid", 64'(rsp_valid), 0);
    chk("abort_rdata", rsp_rdata, 0);
    rst = 1'b0;
    step();
    chk("abort_idle", 64'(req_ready), 1);
    chk("abort_b_low", 64'(b_ready), 0);

    // SC without a prior LR
    aw0 = aw_cycles;
`ifdef AXI_RISCV_AMO_INIT_SC_FAIL_FAST_EN
    send(4'd1, 32'h3000, 2'd3, 64'd9);
    chk("ff_rsp_valid", 64'(rsp_valid), 1);
    chk("ff_rdata", rsp_rdata, 1);
    chk("ff_err", 64'(rsp_err), 0);
    take_rsp();
    chk("ff_no_aw", 64'(aw_cycles - aw0), 0);
`else
    send(4'd1, 32'h3000, 2'd3, 64'd9);
    chk("sc_bus_aw", 64'(aw_valid), 1);
    write_both();
    give_b(2'b00, 4'(ID));
    chk("sc_bus_rdata", rsp_rdata, 1);
    chk("sc_bus_err", 64'(rsp_err), 0);
    take_rsp();
    chk("sc_bus_aw_cnt", 64'(aw_cycles - aw0), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
